// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a 16 x 8-bit register file, sda/scl oversampled in the clk domain.
// Write: address, pointer, data bytes. Read: address with R/W=1, auto-incrementing pointer.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h25,
    parameter int         NUM_REGS    = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl,
    inout  wire        sda,
    input  logic [3:0] reg_raddr,
    output logic [7:0] reg_rdata,
    output logic       wr_pulse,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_p, sda_s1, sda_s2, sda_p;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       drive_low, rw;
    logic [3:0] cnt, ptr;
    logic [6:0] sh, tx;
    logic [7:0] rx;
    logic [7:0] regs [NUM_REGS];

    assign scl_rise  = scl_s2 & ~scl_p;
    assign scl_fall  = ~scl_s2 & scl_p;
    assign start_det = scl_s2 & scl_p & sda_p & ~sda_s2;
    assign stop_det  = scl_s2 & scl_p & ~sda_p & sda_s2;
    assign rx        = {sh, sda_s2};
    assign sda       = drive_low ? 1'b0 : 1'bz;
    assign reg_rdata = regs[reg_raddr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {scl_s1, scl_s2, scl_p} <= 3'b111;
            {sda_s1, sda_s2, sda_p} <= 3'b111;
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            sh        <= '0;
            tx        <= '0;
            rw        <= 1'b0;
            drive_low <= 1'b0;
            busy      <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            {scl_s1, scl_s2, scl_p} <= {scl, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_p} <= {sda, sda_s1, sda_s2};
            wr_pulse <= 1'b0;
            if (start_det) begin
                state     <= ADDR;
                cnt       <= '0;
                drive_low <= 1'b0;
                busy      <= 1'b1;
            end else if (stop_det) begin
                state     <= IDLE;
                drive_low <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        sh  <= rx[6:0];
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            rw    <= rx[0];
                            state <= (rx[7:1] == TARGET_ADDR) ? ADDR_ACK : IDLE;
                            busy  <= rx[7:1] == TARGET_ADDR;
                        end
                    end
                    PTR: if (scl_rise) begin
                        sh  <= rx[6:0];
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            ptr   <= rx[3:0];
                            state <= PTR_ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        sh  <= rx[6:0];
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            regs[ptr] <= rx;
                            wr_pulse  <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= rx;
                            ptr       <= ptr + 4'd1;
                            state     <= WDATA_ACK;
                        end
                    end
                    // First fall drives the ACK low, the second one ends it
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        cnt <= '0;
                        if (!drive_low) begin
                            drive_low <= 1'b1;
                        end else if (state == ADDR_ACK && rw) begin
                            state     <= RDATA;
                            tx        <= regs[ptr][6:0];
                            drive_low <= ~regs[ptr][7];
                        end else begin
                            state     <= (state == ADDR_ACK) ? PTR : WDATA;
                            drive_low <= 1'b0;
                        end
                    end
                    RDATA: if (scl_rise) begin
                        cnt <= cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            drive_low <= 1'b0;
                            ptr       <= ptr + 4'd1;
                            state     <= RDATA_ACK;
                        end else begin
                            drive_low <= ~tx[6];
                            tx        <= {tx[5:0], 1'b0};
                        end
                    end
                    RDATA_ACK: if (scl_rise && sda_s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (scl_fall) begin
                        state     <= RDATA;
                        cnt       <= '0;
                        tx        <= regs[ptr][6:0];
                        drive_low <= ~regs[ptr][7];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
